// File: rtl/decode_stage.sv
// RV32/RV64 (+M) decode stage: classifies, builds the immediate and
// registers the result behind a valid/ready output with optional skid entry.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int EN_M = 1,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [8:0]      out_alu_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal,
    output logic            out_ebreak
);

    localparam bit RV64  = (XLEN == 64);
    localparam bit HAS_M = (EN_M != 0);

    localparam logic [2:0] IT_NONE = 3'd0;
    localparam logic [2:0] IT_I    = 3'd1;
    localparam logic [2:0] IT_U    = 3'd2;
    localparam logic [2:0] IT_S    = 3'd3;
    localparam logic [2:0] IT_J    = 3'd4;
    localparam logic [2:0] IT_B    = 3'd5;

    localparam logic [8:0] C_ADD = 9'h001;
    localparam logic [8:0] C_MUL = 9'h002;
    localparam logic [8:0] C_DIV = 9'h004;
    localparam logic [8:0] C_CMP = 9'h008;
    localparam logic [8:0] C_SHF = 9'h010;
    localparam logic [8:0] C_LS  = 9'h020;
    localparam logic [8:0] C_LOG = 9'h040;
    localparam logic [8:0] C_BR  = 9'h080;
    localparam logic [8:0] C_JMP = 9'h100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic [8:0]      alu_class;
        logic            illegal;
        logic            ebreak;
    } dec_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    logic       ebrk;

    assign opc  = in_instr[6:0];
    assign f3   = in_instr[14:12];
    assign f7   = in_instr[31:25];
    assign f6   = in_instr[31:26];
    assign ebrk = (in_instr == 32'h0010_0073);

    logic [8:0]        cls;
    logic [2:0]        ity;
    logic              ill;
    logic signed [31:0] imm_s;
    logic [XLEN-1:0]   imm_x;
    dec_t              dec;

    always_comb begin
        cls = '0;
        ity = IT_NONE;
        ill = 1'b0;
        case (opc)
            7'b0110111, 7'b0010111: ity = IT_U;
            7'b1101111: begin
                ity = IT_J;
                cls = C_JMP;
            end
            7'b1100111: begin
                ity = IT_I;
                cls = C_JMP;
                ill = (f3 != 3'b000);
            end
            7'b1100011: begin
                ity = IT_B;
                cls = C_BR;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin
                ity = IT_I;
                cls = C_LS;
                ill = (f3 == 3'b111) ||
                      (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            7'b0100011: begin
                ity = IT_S;
                cls = C_LS;
                ill = f3[2] || (!RV64 && f3 == 3'b011);
            end
            7'b0010011: begin
                ity = IT_I;
                case (f3)
                    3'b000:         cls = C_ADD;
                    3'b010, 3'b011: cls = C_CMP;
                    3'b001: begin
                        cls = C_SHF;
                        ill = (f6 != 6'b000000) ||
                              (!RV64 && in_instr[25]);
                    end
                    3'b101: begin
                        cls = C_SHF;
                        ill = (f6 != 6'b000000 && f6 != 6'b010000) ||
                              (!RV64 && in_instr[25]);
                    end
                    default:        cls = C_LOG;
                endcase
            end
            7'b0011011: begin
                ity = IT_I;
                ill = !RV64;
                case (f3)
                    3'b000: cls = C_ADD;
                    3'b001: begin
                        cls = C_SHF;
                        ill = ill || (f7 != 7'b0000000);
                    end
                    3'b101: begin
                        cls = C_SHF;
                        ill = ill ||
                              (f7 != 7'b0000000 && f7 != 7'b0100000);
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'b0110011: begin
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:         cls = C_ADD;
                            3'b001, 3'b101: cls = C_SHF;
                            3'b010, 3'b011: cls = C_CMP;
                            default:        cls = C_LOG;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  cls = C_ADD;
                            3'b101:  cls = C_SHF;
                            default: ill = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        cls = f3[2] ? C_DIV : C_MUL;
                        ill = !HAS_M;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'b0111011: begin
                ill = !RV64;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:         cls = C_ADD;
                            3'b001, 3'b101: cls = C_SHF;
                            default:        ill = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  cls = C_ADD;
                            3'b101:  cls = C_SHF;
                            default: ill = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        ill = ill || !HAS_M;
                        case (f3)
                            3'b000:  cls = C_MUL;
                            3'b100, 3'b101,
                            3'b110, 3'b111: cls = C_DIV;
                            default: ill = 1'b1;
                        endcase
                    end
                    default: ill = 1'b1;
                endcase
            end
            // Only ebreak is decoded from SYSTEM; ecall/csr trap as illegal
            7'b1110011: ill = !ebrk;
            default:    ill = 1'b1;
        endcase

        if (ill) begin
            cls = '0;
            ity = IT_NONE;
        end

        case (ity)
            IT_I: imm_s = {{20{in_instr[31]}}, in_instr[31:20]};
            IT_U: imm_s = {in_instr[31:12], 12'b0};
            IT_S: imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                           in_instr[11:7]};
            IT_J: imm_s = {{11{in_instr[31]}}, in_instr[31],
                           in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            IT_B: imm_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            default: imm_s = '0;
        endcase
        imm_x = XLEN'(imm_s);

        dec = '{in_pc, in_instr, imm_x, ity, cls, ill, ebrk};
    end

    dec_t out_q, out_d;
    dec_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic acc, cons;

    assign in_ready = (SKID != 0) ? in_ready_q
                                  : (~out_valid_q | out_ready);
    assign acc  = in_valid & in_ready;
    assign cons = out_valid_q & out_ready;

    // Without SKID the skid entry can never fill, since in_ready drops
    // whenever out is held
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (cons) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = acc;
                if (acc) skid_d = dec;
            end else if (acc) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            if (out_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_instr     = out_q.instr;
    assign out_imm       = out_q.imm;
    assign out_imm_type  = out_q.imm_type;
    assign out_alu_class = out_q.alu_class;
    assign out_illegal   = out_q.illegal;
    assign out_ebreak    = out_q.ebreak;
    assign out_rd        = out_q.instr[11:7];
    assign out_rs1       = out_q.instr[19:15];
    assign out_rs2       = out_q.instr[24:20];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: RV64+M with skid (a_*) beside RV32 without M or skid (b_*).
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_in_instr = '0, a_out_instr;
    logic [63:0] a_in_pc = '0, a_out_pc, a_out_imm;
    logic [2:0]  a_out_imm_type;
    logic [8:0]  a_out_alu_class;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic        a_out_illegal, a_out_ebreak;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_in_instr = '0, b_out_instr;
    logic [31:0] b_in_pc = '0, b_out_pc, b_out_imm;
    logic [2:0]  b_out_imm_type;
    logic [8:0]  b_out_alu_class;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic        b_out_illegal, b_out_ebreak;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .EN_M(1), .SKID(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_instr(a_out_instr),
        .out_imm(a_out_imm), .out_imm_type(a_out_imm_type),
        .out_alu_class(a_out_alu_class),
        .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_illegal(a_out_illegal), .out_ebreak(a_out_ebreak)
    );

    decode_stage #(.XLEN(32), .EN_M(0), .SKID(0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr),
        .out_imm(b_out_imm), .out_imm_type(b_out_imm_type),
        .out_alu_class(b_out_alu_class),
        .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_illegal(b_out_illegal), .out_ebreak(b_out_ebreak)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
        a_in_valid  = 1'b1;
        a_in_instr  = instr;
        a_in_pc     = pc;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_instr  = instr;
        b_in_pc     = pc[31:0];
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_pc", a_out_pc, 0);
        chk("rst_a_instr", a_out_instr, 0);
        chk("rst_a_imm", a_out_imm, 0);
        chk("rst_a_ityp", a_out_imm_type, 0);
        chk("rst_a_cls", a_out_alu_class, 0);
        chk("rst_a_rd", a_out_rd, 0);
        chk("rst_b_valid", b_out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_a_rdy", a_in_ready, 1);
        chk("rst_b_rdy", b_in_ready, 1);

        issue(32'hFFF0_0093, 64'h1000);
        chk("addi_a_valid", a_out_valid, 1);
        chk("addi_a_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_a_ityp", a_out_imm_type, 1);
        chk("addi_a_cls", a_out_alu_class, 9'h001);
        chk("addi_a_rd", a_out_rd, 1);
        chk("addi_a_pc", a_out_pc, 64'h1000);
        chk("addi_a_ill", a_out_illegal, 0);
        chk("addi_b_imm", b_out_imm, 32'hFFFF_FFFF);
        chk("addi_b_ill", b_out_illegal, 0);

        issue(32'hFE20_BC23, 64'h1004);
        chk("sd_a_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_a_ityp", a_out_imm_type, 3);
        chk("sd_a_cls", a_out_alu_class, 9'h020);
        chk("sd_a_rs1", a_out_rs1, 1);
        chk("sd_a_rs2", a_out_rs2, 2);
        chk("sd_b_ill", b_out_illegal, 1);
        chk("sd_b_cls", b_out_alu_class, 0);
        chk("sd_b_imm", b_out_imm, 0);

        issue(32'hFE00_0EE3, 64'h1008);
        chk("beq_a_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_a_ityp", a_out_imm_type, 5);
        chk("beq_a_cls", a_out_alu_class, 9'h080);

        issue(32'h8000_00B7, 64'h100C);
        chk("lui_a_imm", a_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_a_ityp", a_out_imm_type, 2);
        chk("lui_a_cls", a_out_alu_class, 0);
        chk("lui_a_ill", a_out_illegal, 0);
        chk("lui_b_imm", b_out_imm, 32'h8000_0000);

        issue(32'h0220_80B3, 64'h1010);
        chk("mul_a_cls", a_out_alu_class, 9'h002);
        chk("mul_a_ill", a_out_illegal, 0);
        chk("mul_b_ill", b_out_illegal, 1);
        chk("mul_b_cls", b_out_alu_class, 0);

        issue(32'h0000_009B, 64'h1014);
        chk("addiw_a_ill", a_out_illegal, 0);
        chk("addiw_a_cls", a_out_alu_class, 9'h001);
        chk("addiw_b_ill", b_out_illegal, 1);
        chk("addiw_b_ityp", b_out_imm_type, 0);

        issue(32'h0200_1093, 64'h1018);
        chk("slli_a_cls", a_out_alu_class, 9'h010);
        chk("slli_a_imm", a_out_imm, 64'h20);
        chk("slli_b_ill", b_out_illegal, 1);
        chk("slli_b_cls", b_out_alu_class, 0);
        chk("slli_b_ityp", b_out_imm_type, 0);

        issue(32'h0010_0073, 64'h101C);
        chk("ebrk_a_ebrk", a_out_ebreak, 1);
        chk("ebrk_a_ill", a_out_illegal, 0);
        chk("ebrk_b_ebrk", b_out_ebreak, 1);
        chk("ebrk_b_ill", b_out_illegal, 0);

        @(posedge clk);
        #1;
        chk("drain_a_valid", a_out_valid, 0);
        chk("drain_b_valid", b_out_valid, 0);

        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_pc     = 64'h8000_0000;
        a_in_instr  = 32'h0010_0093;
        @(posedge clk);
        #1;
        chk("skid_rdy0", a_in_ready, 1);
        a_in_pc    = 64'h8000_0004;
        a_in_instr = 32'h0020_0113;
        @(posedge clk);
        #1;
        chk("skid_rdy1", a_in_ready, 0);
        chk("skid_pc1", a_out_pc, 64'h8000_0000);
        a_in_pc    = 64'h8000_0008;
        a_in_instr = 32'h0030_0193;
        @(posedge clk);
        #1;
        chk("skid_rdy2", a_in_ready, 0);
        chk("skid_hold_pc", a_out_pc, 64'h8000_0000);
        chk("skid_hold_ins", a_out_instr, 32'h0010_0093);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("skid_out_pc4", a_out_pc, 64'h8000_0004);
        chk("skid_rdy_up", a_in_ready, 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        chk("skid_out_pc8", a_out_pc, 64'h8000_0008);
        chk("skid_out_rd8", a_out_rd, 3);
        @(posedge clk);
        #1;
        chk("skid_empty", a_out_valid, 0);

        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_pc     = 64'h100;
        @(posedge clk);
        #1;
        a_in_pc = 64'h104;
        @(posedge clk);
        #1;
        chk("fl_full_rdy", a_in_ready, 0);
        flush       = 1'b1;
        a_in_pc     = 64'h108;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_pc     = 32'h200;
        b_in_instr  = 32'h0010_0093;
        #1;
        chk("fl_b_rdy", b_in_ready, 1);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk("fl_a_valid", a_out_valid, 0);
        chk("fl_a_rdy", a_in_ready, 1);
        chk("fl_b_valid", b_out_valid, 0);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fl_a_stay", a_out_valid, 0);

        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_pc     = 64'h300;
        a_in_instr  = 32'hFFF0_0093;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        chk("ar_pre_valid", a_out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", a_out_valid, 0);
        chk("ar_pc", a_out_pc, 0);
        chk("ar_imm", a_out_imm, 0);
        chk("ar_instr", a_out_instr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h0080_006F, 64'h400);
        chk("jal_a_imm", a_out_imm, 64'h8);
        chk("jal_a_ityp", a_out_imm_type, 4);
        chk("jal_a_cls", a_out_alu_class, 9'h100);
        chk("jal_b_imm", b_out_imm, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
